// File: rtl/exe_div_stage.sv
// exe_div_stage: execute-stage result unit (ALU + EX/MEM output register).
// Define EXE_DIV_EN to build the 32-iteration restoring DIV/MOD unit; otherwise ops 11..14 return 0.

module exe_alu (
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  // Single-cycle integer ops; divide and reserved codes yield zero
  always_comb begin
    o_result = 32'd0;
    case (i_op)
      4'd0:    o_result = i_a + i_b;
      4'd1:    o_result = i_a - i_b;
      4'd2:    o_result = i_a & i_b;
      4'd3:    o_result = i_a | i_b;
      4'd4:    o_result = ~(i_a | i_b);
      4'd5:    o_result = i_a ^ i_b;
      4'd6:    o_result = i_a << i_b[4:0];
      4'd7:    o_result = i_a >> i_b[4:0];
      4'd8:    o_result = 32'($signed(i_a) >>> i_b[4:0]);
      4'd9:    o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
      4'd10:   o_result = {31'd0, (i_a < i_b)};
      default: o_result = 32'd0;
    endcase
  end

endmodule

module exe_div_stage #(
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic [31:0]     out_pc,
  output logic            busy
);

  logic            r_out_valid;
  logic [31:0]     r_out_result;
  logic [RD_W-1:0] r_out_rd;
  logic [31:0]     r_out_pc;

  logic            w_out_free;
  logic            w_accept;
  logic            w_out_load;
  logic [31:0]     w_alu_result;
  logic [31:0]     w_load_result;
  logic [RD_W-1:0] w_load_rd;
  logic [31:0]     w_load_pc;

  exe_alu u_alu (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_alu_result)
  );

  assign w_out_free = !r_out_valid || out_ready;

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t      r_state;
  div_state_t      w_state_next;
  logic [4:0]      r_cnt;
  logic [31:0]     r_rem;
  logic [31:0]     r_quo;
  logic [31:0]     r_dvsr;
  logic            r_is_mod;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_dz;
  logic [RD_W-1:0] r_div_rd;
  logic [31:0]     r_div_pc;

  logic            w_is_div;
  logic            w_signed;
  logic            w_div_start;
  logic            w_div_finish;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic [32:0]     w_shift;
  logic [32:0]     w_diff;
  logic [31:0]     w_quo_fix;
  logic [31:0]     w_rem_fix;
  logic [31:0]     w_div_result;

  assign w_is_div     = (in_op >= 4'd11) && (in_op <= 4'd14);
  assign w_signed     = (in_op == 4'd11) || (in_op == 4'd13);
  assign w_a_mag      = (w_signed && in_a[31]) ? (32'd0 - in_a) : in_a;
  assign w_b_mag      = (w_signed && in_b[31]) ? (32'd0 - in_b) : in_b;
  assign in_ready     = !flush && (r_state == S_IDLE) && w_out_free;
  assign w_accept     = in_valid && in_ready;
  assign w_div_start  = w_accept && w_is_div;
  assign w_div_finish = (r_state == S_DONE) && w_out_free;

  // Shifted partial remainder and trial subtraction; a borrow in bit 32 means restore
  assign w_shift      = {r_rem, r_quo[31]};
  assign w_diff       = w_shift - {1'b0, r_dvsr};
  // Zero divisor yields all-ones quotient; remainder path already returns the dividend
  assign w_quo_fix    = r_dz ? 32'hFFFF_FFFF : (r_qneg ? (32'd0 - r_quo) : r_quo);
  assign w_rem_fix    = r_rneg ? (32'd0 - r_rem) : r_rem;
  assign w_div_result = r_is_mod ? w_rem_fix : w_quo_fix;

  // Divider FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Divider FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_div_start) w_state_next = S_DIV;
        else             w_state_next = S_IDLE;
      end
      S_DIV: begin
        if (r_cnt == 5'd31) w_state_next = S_DONE;
        else                w_state_next = S_DIV;
      end
      S_DONE: begin
        if (w_div_finish) w_state_next = S_IDLE;
        else              w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Divider FSM outputs
  always_comb begin
    busy = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_DIV:   busy = 1'b1;
      S_DONE:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Operand latch at accept and one restoring iteration per cycle in DIV
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvsr   <= 32'd0;
      r_is_mod <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_div_rd <= '0;
      r_div_pc <= 32'd0;
    end else if (flush) begin
      r_cnt <= 5'd0;
    end else if (w_div_start) begin
      r_cnt    <= 5'd0;
      r_rem    <= 32'd0;
      r_quo    <= w_a_mag;
      r_dvsr   <= w_b_mag;
      r_is_mod <= (in_op == 4'd13) || (in_op == 4'd14);
      r_qneg   <= w_signed && (in_a[31] ^ in_b[31]);
      r_rneg   <= w_signed && in_a[31];
      r_dz     <= (in_b == 32'd0);
      r_div_rd <= in_rd;
      r_div_pc <= in_pc;
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shift[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Output register source: finished divide or a freshly accepted ALU op
  always_comb begin
    w_out_load    = 1'b0;
    w_load_result = w_alu_result;
    w_load_rd     = in_rd;
    w_load_pc     = in_pc;
    if (w_div_finish) begin
      w_out_load    = 1'b1;
      w_load_result = w_div_result;
      w_load_rd     = r_div_rd;
      w_load_pc     = r_div_pc;
    end else if (w_accept && !w_is_div) begin
      w_out_load = 1'b1;
    end else begin
      w_out_load = 1'b0;
    end
  end
`else
  assign in_ready = !flush && w_out_free;
  assign w_accept = in_valid && in_ready;
  assign busy     = 1'b0;

  // Without the divider every accepted op (11..14 included) goes through the ALU
  always_comb begin
    w_out_load    = 1'b0;
    w_load_result = w_alu_result;
    w_load_rd     = in_rd;
    w_load_pc     = in_pc;
    if (w_accept) begin
      w_out_load = 1'b1;
    end else begin
      w_out_load = 1'b0;
    end
  end
`endif

  // EX/MEM register: reset, then flush, then reload, then drain on out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_rd     <= '0;
      r_out_pc     <= 32'd0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_load_result;
      r_out_rd     <= w_load_rd;
      r_out_pc     <= w_load_pc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_pc     = r_out_pc;

endmodule
